// File: rtl/ahb_wb_burst_bridge.sv
// AHB-slave to Wishbone-master bridge with parametrised widths, hsize byte lanes,
// a Wishbone cycle held open across AHB bursts, and a two-cycle ERROR response.
module ahb_wb_burst_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            hsel,
  input  logic [AW-1:0]   haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic [DW-1:0]   hwdata,
  output logic            hready,
  output logic [DW-1:0]   hrdata,
  output logic [1:0]      hresp,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [DW-1:0]   dat_i
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_HOLD, S_ERR1, S_ERR2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          illegal;
  logic [NB-1:0] lane_mask;
  logic [NB-1:0] sel_dec;
  logic          unused_ok;

  // hburst carries no behaviour; it is folded here only to keep it connected.
  assign unused_ok = ^hburst;

  assign dat_o = (stb_o && we_o) ? hwdata : '0;

  always_comb begin
    accept    = hsel && hready && htrans[1];
    illegal   = 1'b0;
    lane_mask = '1;
    if (32'(hsize) > 32'(LW)) illegal = 1'b1;
    case (hsize)
      3'd0: lane_mask = NB'(1);
      3'd1: begin
        lane_mask = NB'(3);
        if (haddr[0]) illegal = 1'b1;
      end
      3'd2: begin
        lane_mask = NB'(15);
        if (haddr[1:0] != 2'd0) illegal = 1'b1;
      end
      3'd3: begin
        lane_mask = '1;
        if (haddr[2:0] != 3'd0) illegal = 1'b1;
      end
      default: lane_mask = '1;
    endcase
    sel_dec = lane_mask << haddr[LW-1:0];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hready <= 1'b1;
      hresp  <= RESP_OKAY;
      hrdata <= '0;
      cyc_o  <= 1'b0;
      stb_o  <= 1'b0;
      we_o   <= 1'b0;
      adr_o  <= '0;
      sel_o  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HOLD, S_ERR2: begin
          if (accept) begin
            adr_o <= haddr;
            we_o  <= hwrite;
            sel_o <= sel_dec;
            hready <= 1'b0;
            if (illegal) begin
              state <= S_ERR1;
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
              hresp <= RESP_ERR;
            end else begin
              state <= S_WB;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              hresp <= RESP_OKAY;
              cnt   <= '0;
            end
          end else if (state == S_HOLD && hsel && htrans == HT_BUSY) begin
            state  <= S_HOLD;
            hready <= 1'b1;
            hresp  <= RESP_OKAY;
          end else begin
            state  <= S_IDLE;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            hready <= 1'b1;
            hresp  <= RESP_OKAY;
          end
        end
        S_WB: begin
          // err_i takes priority over a simultaneous ack_i.
          if (err_i || (TIMEOUT != 0 && !ack_i && cnt == CW'(TIMEOUT))) begin
            state  <= S_ERR1;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            hready <= 1'b0;
            hresp  <= RESP_ERR;
          end else if (ack_i) begin
            state  <= S_HOLD;
            stb_o  <= 1'b0;
            hready <= 1'b1;
            hresp  <= RESP_OKAY;
            if (!we_o) hrdata <= dat_i;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          hready <= 1'b1;
          hresp  <= RESP_ERR;
        end
        default: begin
          state  <= S_IDLE;
          cyc_o  <= 1'b0;
          stb_o  <= 1'b0;
          hready <= 1'b1;
          hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule
